// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state type,
// default geometry and the request legality check.
package lsu_pkg;

  localparam int unsigned LSU_WIDTH  = 32;
  localparam int unsigned LSU_ADDR_W = 9;

  // RV32I load/store funct3 codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  // True when a request must be rejected without touching memory:
  // illegal funct3, misaligned access, or address beyond the memory.
  function automatic logic lsu_req_err(
    input logic       is_store,
    input logic [2:0] funct3,
    input logic [1:0] lane,
    input logic       high_nz
  );
    logic bad_f3;
    logic misal;
    if (is_store) begin
      bad_f3 = (funct3 > F3_W);
    end else begin
      bad_f3 = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end
    case (funct3)
      F3_H, F3_HU: misal = lane[0];
      F3_W:        misal = |lane;
      default:     misal = 1'b0;
    endcase
    return bad_f3 | misal | high_nz;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic for the load/store unit.
//  lane         byte offset within the word (addr[1:0])
//  funct3       access size / signedness
//  old_word     word read from memory
//  wdata        store data (rs2)
//  load_data_c  selected lane, sign- or zero-extended
//  store_word_c old word with the store lane replaced (full wdata for SW)
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int unsigned Width = LSU_WIDTH
) (
  input  logic [1:0]       lane,
  input  logic [2:0]       funct3,
  input  logic [Width-1:0] old_word,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] load_data_c,
  output logic [Width-1:0] store_word_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Load extraction and extension
  always_comb begin
    byte_sel = old_word[{lane, 3'b000} +: 8];
    half_sel = old_word[{lane[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    load_data_c = {{(Width-8){byte_sel[7]}}, byte_sel};
      F3_BU:   load_data_c = {{(Width-8){1'b0}}, byte_sel};
      F3_H:    load_data_c = {{(Width-16){half_sel[15]}}, half_sel};
      F3_HU:   load_data_c = {{(Width-16){1'b0}}, half_sel};
      default: load_data_c = old_word;
    endcase
  end

  // Store merge into the previously read word
  always_comb begin
    store_word_c = old_word;
    case (funct3)
      F3_B:    store_word_c[{lane, 3'b000} +: 8]      = wdata[7:0];
      F3_H:    store_word_c[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_word_c = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Sequential load/store front-end for a word-wide data memory without byte
// enables. One request at a time; sub-word stores are read-modify-write.
//  clk, reset                  clock, synchronous active-high reset
//  req_valid/req_ready         request handshake (ready only in IDLE)
//  req_is_store/funct3/addr/wdata  request payload, latched on acceptance
//  resp_valid/resp_ready       response handshake, held until taken
//  resp_rdata/resp_err         extended load data / error flag
//  mem_read/mem_write          one-cycle memory strobes
//  mem_addr/mem_wdata          word index and write word to memory
//  mem_rdata                   combinational read data from memory
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned Width  = LSU_WIDTH,
  parameter int unsigned ADDR_W = LSU_ADDR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_is_store,
  input  logic [2:0]       req_funct3,
  input  logic [Width-1:0] req_addr,
  input  logic [Width-1:0] req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [Width-1:0] resp_rdata,
  output logic             resp_err,
  output logic             mem_read,
  output logic             mem_write,
  output logic [Width-1:0] mem_addr,
  output logic [Width-1:0] mem_wdata,
  input  logic [Width-1:0] mem_rdata
);

  lsu_state_t       state;
  logic [1:0]       lane_q;
  logic [2:0]       f3_q;
  logic             store_q;
  logic [Width-1:0] wdata_q;
  logic             mem_write_q;

  logic             high_nz_c;
  logic             req_err_c;
  logic [Width-1:0] word_idx_c;
  logic [Width-1:0] load_data_c;
  logic [Width-1:0] store_word_c;

  // Request decode
  always_comb begin
    high_nz_c  = |req_addr[Width-1:ADDR_W+2];
    req_err_c  = lsu_req_err(req_is_store, req_funct3, req_addr[1:0], high_nz_c);
    word_idx_c = Width'(req_addr[ADDR_W+1:2]);
  end

  // Lane logic works on the live memory word during RD
  lsu_lane_align #(
    .Width(Width)
  ) u_align (
    .lane        (lane_q),
    .funct3      (f3_q),
    .old_word    (mem_rdata),
    .wdata       (wdata_q),
    .load_data_c (load_data_c),
    .store_word_c(store_word_c)
  );

  // A reset arriving during WR must not let the write reach memory
  assign mem_write = mem_write_q & ~reset;

  // FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
      mem_read    <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      lane_q      <= '0;
      f3_q        <= '0;
      store_q     <= 1'b0;
      wdata_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            lane_q    <= req_addr[1:0];
            f3_q      <= req_funct3;
            store_q   <= req_is_store;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (req_err_c) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (!req_is_store || (req_funct3 != F3_W)) begin
              // loads and sub-word stores read the word first
              state    <= RD;
              mem_read <= 1'b1;
              mem_addr <= word_idx_c;
            end else begin
              state       <= WR;
              mem_write_q <= 1'b1;
              mem_addr    <= word_idx_c;
              mem_wdata   <= req_wdata;
            end
          end
        end
        RD: begin
          mem_read <= 1'b0;
          if (store_q) begin
            state       <= WR;
            mem_write_q <= 1'b1;
            mem_wdata   <= store_word_c;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_data_c;
          end
        end
        WR: begin
          mem_write_q <= 1'b0;
          mem_wdata   <= '0;
          state       <= RESP;
          resp_valid  <= 1'b1;
          resp_err    <= 1'b0;
          resp_rdata  <= '0;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a 512-word memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    int          acc;
  } exp_t;

  logic [31:0] mem     [512];
  logic [31:0] ref_mem [512];
  exp_t        exp_q[$];
  exp_t        cur;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nrd = 0;
  int nwr = 0;
  bit in_resp = 0;
  bit bp_hold = 0;
  logic [31:0] held;

  load_store_unit dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_is_store(req_is_store),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = mem[mem_addr[8:0]];

  always @(posedge clk) if (mem_write) mem[mem_addr[8:0]] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Reference behaviour from the architectural rules
  function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output exp_t e);
    int unsigned size, idx, sh;
    logic [31:0] w, mask, v;
    bit legal;
    e.rdata = 32'h0; e.err = 1'b0; e.lat = 1; e.nrd = 0; e.nwr = 0; e.acc = 0;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f3[1:0];
    if (!legal || (a % size) != 0 || a >= 32'd2048) begin
      e.err = 1'b1;
      return;
    end
    idx = a / 4;
    sh  = 8 * (a % 4);
    w   = ref_mem[idx];
    mask = (size == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * size)) - 1);
    if (!st) begin
      e.lat = 2; e.nrd = 1;
      v = (w >> sh) & mask;
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
      e.rdata = v;
    end else if (size == 4) begin
      ref_mem[idx] = wd;
      e.lat = 2; e.nwr = 1;
    end else begin
      mask = mask << sh;
      ref_mem[idx] = (w & ~mask) | ((wd << sh) & mask);
      e.lat = 3; e.nrd = 1; e.nwr = 1;
    end
  endfunction

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int g = 0;
    @(negedge clk);
    while (!req_ready) begin
      g++;
      if (g > 100) begin
        checks++; errors++;
        $display("FAIL req_ready_timeout addr %h", a);
        return;
      end
      @(negedge clk);
    end
    model(st, f3, a, wd, e);
    e.acc = cyc;
    exp_q.push_back(e);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = $urandom;
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || resp_valid) && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending %0d", exp_q.size());
    end
  endtask

  // Monitor: strobe accounting and response scoreboard
  always @(negedge clk) begin
    if (reset) begin
      in_resp = 0; nrd = 0; nwr = 0;
    end else begin
      if (mem_read) nrd++;
      if (mem_write) nwr++;
      if (mem_read || mem_write) chk("mem_addr_high", {9'h0, mem_addr[31:9]}, 32'h0);
      if (!mem_write) chk("mem_wdata_idle", mem_wdata, 32'h0);
      if (resp_valid) begin
        chk("req_ready_in_resp", {31'h0, req_ready}, 32'h0);
        if (!in_resp) begin
          in_resp = 1;
          held = resp_rdata;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_resp rdata %h", resp_rdata);
          end else begin
            cur = exp_q.pop_front();
            chk("resp_err", {31'h0, resp_err}, {31'h0, cur.err});
            chk("resp_rdata", resp_rdata, cur.rdata);
            chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
            chk("read_pulses", 32'(nrd), 32'(cur.nrd));
            chk("write_pulses", 32'(nwr), 32'(cur.nwr));
          end
          nrd = 0; nwr = 0;
        end else begin
          chk("resp_rdata_stable", resp_rdata, held);
        end
      end else begin
        in_resp = 0;
      end
    end
  end

  // Consumer with random backpressure
  initial begin
    resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      resp_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] old7;
    reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 512; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_read", {31'h0, mem_read}, 32'h0);
    chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);

    // Sign and zero extension of a byte lane
    mem[5] = 32'h8081_F0F1; ref_mem[5] = 32'h8081_F0F1;
    issue(1'b0, 3'b000, 32'h16, 32'h0);
    issue(1'b0, 3'b100, 32'h16, 32'h0);
    drain();

    // Sub-word read-modify-write
    mem[5] = 32'h1122_3344; ref_mem[5] = 32'h1122_3344;
    issue(1'b1, 3'b000, 32'h15, 32'h0000_00AA);
    drain();
    chk("sb_merge", mem[5], 32'h1122_AA44);

    // Error cases
    issue(1'b1, 3'b001, 32'h13, 32'h1234_5678);
    issue(1'b0, 3'b010, 32'h0000_0800, 32'h0);
    drain();

    // Back-to-back store then load
    issue(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF);
    issue(1'b0, 3'b010, 32'h20, 32'h0);
    drain();
    chk("sw_mem", mem[8], 32'hDEAD_BEEF);

    // Held response under backpressure
    bp_hold = 1;
    issue(1'b0, 3'b010, 32'h20, 32'h0);
    repeat (5) @(negedge clk);
    chk("bp_resp_held", {31'h0, resp_valid}, 32'h1);
    chk("bp_rdata", resp_rdata, 32'hDEAD_BEEF);
    bp_hold = 0;
    drain();

    // Reset during the write cycle of a byte store
    mem[7] = 32'h0BAD_F00D; ref_mem[7] = 32'h0BAD_F00D;
    old7 = mem[7];
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h1D; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rst_test_rd", {31'h0, mem_read}, 32'h1);
    @(negedge clk);
    chk("rst_test_wr", {31'h0, mem_write}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_mem", mem[7], old7);
    chk("rst_mid_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_mid_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_mid_mem_write", {31'h0, mem_write}, 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_mid_no_resp", {31'h0, resp_valid}, 32'h0);

    // Randomized traffic over a small window plus occasional far addresses
    for (int n = 0; n < 300; n++) begin
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(11, 31));
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end
    drain();

    begin
      int bad = 0;
      for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) bad++;
      chk("final_mem_mismatches", 32'(bad), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
